// File: rtl/mem_access_stage_pkg.sv
// MEM stage shared types: opcode encodings, FSM states,
// access decode and byte-lane helpers.
package mem_access_stage_pkg;

  localparam logic [11:0] OP_LB  = 12'h001;
  localparam logic [11:0] OP_LH  = 12'h002;
  localparam logic [11:0] OP_LW  = 12'h004;
  localparam logic [11:0] OP_LBU = 12'h008;
  localparam logic [11:0] OP_LHU = 12'h010;
  localparam logic [11:0] OP_SB  = 12'h020;
  localparam logic [11:0] OP_SH  = 12'h040;
  localparam logic [11:0] OP_SW  = 12'h080;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      ld;
    logic      st;
    mem_size_e size;
    logic      uns;
  } mem_op_t;

  function automatic mem_op_t decode_op(
    input logic [11:0] op
  );
    mem_op_t d;
    d.ld   = 1'b0;
    d.st   = 1'b0;
    d.size = SZ_W;
    d.uns  = 1'b0;
    unique case (op)
      OP_LB: begin
        d.ld   = 1'b1;
        d.size = SZ_B;
      end
      OP_LH: begin
        d.ld   = 1'b1;
        d.size = SZ_H;
      end
      OP_LW: begin
        d.ld   = 1'b1;
        d.size = SZ_W;
      end
      OP_LBU: begin
        d.ld   = 1'b1;
        d.size = SZ_B;
        d.uns  = 1'b1;
      end
      OP_LHU: begin
        d.ld   = 1'b1;
        d.size = SZ_H;
        d.uns  = 1'b1;
      end
      OP_SB: begin
        d.st   = 1'b1;
        d.size = SZ_B;
      end
      OP_SH: begin
        d.st   = 1'b1;
        d.size = SZ_H;
      end
      OP_SW: begin
        d.st   = 1'b1;
        d.size = SZ_W;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(
    input mem_op_t    d,
    input logic [1:0] lane
  );
    logic m;
    m = 1'b0;
    unique case (d.size)
      SZ_W:    m = |lane;
      SZ_H:    m = lane[0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extend_load(
    input mem_op_t     d,
    input logic [31:0] w,
    input logic [1:0]  lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    unique case (d.size)
      SZ_B: r = d.uns ? {24'b0, b}
                      : {{24{b[7]}}, b};
      SZ_H: r = d.uns ? {16'b0, h}
                      : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(
    input mem_op_t    d,
    input logic [1:0] lane
  );
    logic [3:0] be;
    unique case (d.size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(
    input mem_op_t     d,
    input logic [31:0] rs
  );
    logic [31:0] wd;
    unique case (d.size)
      SZ_B:    wd = {4{rs[7:0]}};
      SZ_H:    wd = {2{rs[15:0]}};
      default: wd = rs;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM request bundle into the MEM stage and
// the load data / stall / fault responses back out.
interface mem_access_stage_if;

  logic [31:0] MEM_ALU_OUT;
  logic [31:0] MEM_rs2_val;
  logic        MEM_memread;
  logic        MEM_memwrite;
  logic [11:0] MEM_opcode;
  logic [31:0] MEM_Data_mem_out;
  logic        mem_stall;
  logic        mem_misaligned;

  modport master (
    output MEM_ALU_OUT,
    output MEM_rs2_val,
    output MEM_memread,
    output MEM_memwrite,
    output MEM_opcode,
    input  MEM_Data_mem_out,
    input  mem_stall,
    input  mem_misaligned
  );

  modport slave (
    input  MEM_ALU_OUT,
    input  MEM_rs2_val,
    input  MEM_memread,
    input  MEM_memwrite,
    input  MEM_opcode,
    output MEM_Data_mem_out,
    output mem_stall,
    output mem_misaligned
  );

endinterface

// File: rtl/mem_access_stage_data_mem_array.sv
// Data memory: 2**ADDR_W words of 32 bits, per-byte
// write enables, asynchronous read. Never cleared.
module data_mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  // write only the enabled byte lanes
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: load/store lane handling, extension,
// optional wait-state FSM that stalls the upstream pipe.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_stage_if.slave  mem_if
);

  mem_op_t           w_op;
  logic [1:0]        w_lane;
  logic              w_ld_req;
  logic              w_st_req;
  logic              w_mis;
  logic              w_ok_ld;
  logic              w_ok_st;
  logic [ADDR_W-1:0] w_live_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic [31:0]       w_dout;
  logic              w_stall;
  logic              w_mis_o;
  logic              w_unused;

  assign w_op        = decode_op(mem_if.MEM_opcode);
  assign w_lane      = mem_if.MEM_ALU_OUT[1:0];
  assign w_live_addr = mem_if.MEM_ALU_OUT[ADDR_W+1:2];
  assign w_unused    = ^mem_if.MEM_ALU_OUT[31:ADDR_W+2];

  assign w_ld_req = mem_if.MEM_memread
                  & ~mem_if.MEM_memwrite
                  & w_op.ld;
  assign w_st_req = mem_if.MEM_memwrite & w_op.st;
  assign w_mis    = (w_ld_req | w_st_req)
                  & is_misaligned(w_op, w_lane);
  assign w_ok_ld  = w_ld_req & ~w_mis;
  assign w_ok_st  = w_st_req & ~w_mis;

  data_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  if (WAIT_CYCLES == 0) begin : g_single

    assign w_addr  = w_live_addr;
    assign w_wdata = store_wdata(w_op, mem_if.MEM_rs2_val);
    assign w_we    = (w_ok_st & ~rst)
                   ? store_be(w_op, w_lane) : 4'b0;
    assign w_dout  = w_ok_ld
                   ? extend_load(w_op, w_rdata, w_lane)
                   : 32'b0;
    assign w_stall = 1'b0;
    assign w_mis_o = w_mis;

  end else begin : g_wait

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_lane;
    logic [31:0]       r_rs2;
    mem_op_t           r_op;
    logic [31:0]       r_ld_data;
    logic              w_accept;
    logic              w_commit;
    mem_op_t           w_cur_op;
    logic [1:0]        w_cur_lane;

    assign w_accept = w_ok_ld | w_ok_st;

    // IDLE works from live inputs, later states from the latch
    always_comb begin
      w_cur_op   = r_op;
      w_cur_lane = r_lane;
      w_addr     = r_addr;
      w_wdata    = store_wdata(r_op, r_rs2);
      if (r_state == ST_IDLE) begin
        w_cur_op   = w_op;
        w_cur_lane = w_lane;
        w_addr     = w_live_addr;
        w_wdata    = store_wdata(w_op, mem_if.MEM_rs2_val);
      end
    end

    // next state, stall, commit strobe and outputs
    always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_commit    = 1'b0;
      w_mis_o     = 1'b0;
      w_dout      = 32'b0;
      unique case (r_state)
        ST_IDLE: begin
          w_mis_o = w_mis;
          if (w_accept) begin
            w_stall = 1'b1;
            if (WAIT_CYCLES == 1) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          w_stall = 1'b1;
          if (r_cnt == CW'(2)) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          w_dout      = r_ld_data;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    assign w_we = (w_commit & w_cur_op.st & ~rst)
                ? store_be(w_cur_op, w_cur_lane)
                : 4'b0;

    // state register; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // request latch, wait counter and load data register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt     <= '0;
        r_addr    <= '0;
        r_lane    <= '0;
        r_rs2     <= '0;
        r_op      <= '0;
        r_ld_data <= '0;
      end else begin
        if (r_state == ST_IDLE && w_accept) begin
          r_cnt  <= CW'(WAIT_CYCLES);
          r_addr <= w_live_addr;
          r_lane <= w_lane;
          r_rs2  <= mem_if.MEM_rs2_val;
          r_op   <= w_op;
        end else if (r_state == ST_WAIT) begin
          r_cnt <= r_cnt - CW'(1);
        end
        if (w_commit) begin
          r_ld_data <= w_cur_op.ld
            ? extend_load(w_cur_op, w_rdata, w_cur_lane)
            : 32'b0;
        end
      end
    end

  end

  assign mem_if.MEM_Data_mem_out = rst ? 32'b0 : w_dout;
  assign mem_if.mem_stall        = w_stall & ~rst;
  assign mem_if.mem_misaligned   = w_mis_o & ~rst;

endmodule
